reg_dst_unit: RTL and testbench

REG_DST_UNIT -- requirements
Module: reg_dst_unit

---
 rtl/reg_dst_pkg.sv | 15 +
 rtl/reg_dst_scoreboard.sv | 58 +++++
 rtl/reg_dst_unit.sv | 102 ++++++++++
 tb/tb_reg_dst_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dst_pkg.sv
// rtl/reg_dst_pkg.sv - selector encodings and default constant destinations for reg_dst_unit
package reg_dst_pkg;

    typedef enum logic [2:0] {
        SEL_ADDR0 = 3'b000,
        SEL_ALT   = 3'b001,
        SEL_LINK  = 3'b010,
        SEL_ADDR1 = 3'b011,
        SEL_ADDR2 = 3'b100
    } sel_e;

    localparam int DEF_LINK_ADDR = 31;
    localparam int DEF_ALT_ADDR  = 29;

endpackage

// File: rtl/reg_dst_scoreboard.sv
// rtl/reg_dst_scoreboard.sv - pending-destination mask with hazard lookup; REG_DST_BYPASS_EN lets a same-cycle writeback release the stall
module reg_dst_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    output logic              hazard,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [DEPTH-1:0] look;

    // Next mask: clear first so a set to the same address wins; register 0 never pends
    always_comb begin
        pend_d = pend_q;
        if (clr_en) begin
            pend_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pend_d[set_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Pending mask, discarded immediately on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Mask seen by the hazard lookup; optionally hides the address retiring this cycle
    always_comb begin
        look = pend_q;
`ifdef REG_DST_BYPASS_EN
        if (clr_en) begin
            look[clr_addr] = 1'b0;
        end
`endif
    end

    assign hazard = look[src_a] | look[src_b] | look[dst];
    assign busy   = |pend_q;

endmodule

// File: rtl/reg_dst_unit.sv
// rtl/reg_dst_unit.sv - destination-register select with single output stage and RAW/WAW scoreboard (REG_DST_BYPASS_EN: writeback bypass)
module reg_dst_unit
    import reg_dst_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int LINK_ADDR = DEF_LINK_ADDR,
    parameter int ALT_ADDR  = DEF_ALT_ADDR
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        sel,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              busy
);

    logic [ADDR_W-1:0] dst;
    logic              legal;
    logic              hazard;
    logic              accept;

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_err_q, out_err_d;

    // Selector decode; illegal codes map to register 0 so they never hit the scoreboard
    always_comb begin
        dst   = '0;
        legal = 1'b1;
        case (sel)
            SEL_ADDR0: dst = addr0;
            SEL_ALT:   dst = ADDR_W'(ALT_ADDR);
            SEL_LINK:  dst = ADDR_W'(LINK_ADDR);
            SEL_ADDR1: dst = addr1;
            SEL_ADDR2: dst = addr2;
            default:   legal = 1'b0;
        endcase
    end

    assign in_ready = (!out_valid_q || out_ready) && !hazard && reset_n;
    assign accept   = in_valid && in_ready;

    reg_dst_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (accept && wr_en && legal),
        .set_addr (dst),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .src_a    (src_a),
        .src_b    (src_b),
        .dst      (dst),
        .hazard   (hazard),
        .busy     (busy)
    );

    // Output stage: load on accept, drop valid on a take, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_addr_d  = dst;
            out_err_d   = !legal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage registers, discarded immediately on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_reg_dst_unit.sv
// tb/tb_reg_dst_unit.sv - self-checking bench for reg_dst_unit
module tb_reg_dst_unit;

    localparam int AW = 5;
`ifdef REG_DST_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    sel;
    logic [AW-1:0] addr0, addr1, addr2;
    logic          wr_en;
    logic [AW-1:0] src_a, src_b;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic          out_err;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    reg_dst_unit #(.ADDR_W(AW), .LINK_ADDR(31), .ALT_ADDR(29)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .addr0     (addr0),
        .addr1     (addr1),
        .addr2     (addr2),
        .wr_en     (wr_en),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    sel;
        logic [AW-1:0] exp_addr;
        logic          exp_err;
    } vec_t;

    vec_t tbl[8];

    // reference model state
    bit            m_pend[32];
    bit            m_valid;
    logic [AW-1:0] m_addr;
    bit            m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        sel       = 3'd0;
        addr0     = '0;
        addr1     = '0;
        addr2     = '0;
        wr_en     = 1'b0;
        src_a     = '0;
        src_b     = '0;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_addr   = '0;
    endtask

    task automatic retire(input logic [AW-1:0] a);
        wb_valid = 1'b1;
        wb_addr  = a;
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    function automatic bit ref_legal(input logic [2:0] s);
        return s <= 3'd4;
    endfunction

    function automatic logic [AW-1:0] ref_dst(input logic [2:0] s, input logic [AW-1:0] a0,
                                              input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        if (s == 3'd0) return a0;
        if (s == 3'd1) return 5'd29;
        if (s == 3'd2) return 5'd31;
        if (s == 3'd3) return a1;
        if (s == 3'd4) return a2;
        return 5'd0;
    endfunction

    function automatic bit ref_is_pend(input logic [AW-1:0] a);
        if (BYPASS && wb_valid && wb_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic bit ref_busy();
        for (int i = 0; i < 32; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [AW-1:0] d;
        bit            hz, exp_rdy, acc;
        int            k;

        tbl[0] = '{3'b000, 5'd3,  1'b0};
        tbl[1] = '{3'b001, 5'd29, 1'b0};
        tbl[2] = '{3'b010, 5'd31, 1'b0};
        tbl[3] = '{3'b011, 5'd12, 1'b0};
        tbl[4] = '{3'b100, 5'd17, 1'b0};
        tbl[5] = '{3'b101, 5'd0,  1'b1};
        tbl[6] = '{3'b110, 5'd0,  1'b1};
        tbl[7] = '{3'b111, 5'd0,  1'b1};

        idle();
        reset_n = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        reset_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);

        // selector map
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            sel   = tbl[i].sel;
            addr0 = 5'd3;
            addr1 = 5'd12;
            addr2 = 5'd17;
            #1 chk("tbl_in_ready", in_ready, 1);
            @(negedge clk);
            chk("tbl_out_valid", out_valid, 1);
            chk("tbl_out_addr", out_addr, tbl[i].exp_addr);
            chk("tbl_out_err", out_err, tbl[i].exp_err);
            chk("tbl_busy", busy, 0);
        end
        idle();
        @(negedge clk);
        chk("take_clears_valid", out_valid, 0);

        // link write
        in_valid = 1'b1; sel = 3'b010; wr_en = 1'b1;
        @(negedge clk);
        idle();
        chk("link_addr", out_addr, 31);
        chk("link_valid", out_valid, 1);
        chk("link_busy", busy, 1);
        retire(5'd31);
        chk("link_retired", busy, 0);

        // RAW stall on 8
        in_valid = 1'b1; sel = 3'b000; addr0 = 5'd8; wr_en = 1'b1;
        @(negedge clk);
        chk("raw_busy", busy, 1);
        addr0 = 5'd9; src_a = 5'd8;
        #1 chk("raw_stall0", in_ready, 0);
        @(negedge clk);
        #1 chk("raw_stall1", in_ready, 0);
        wb_valid = 1'b1; wb_addr = 5'd8;
        #1;
        if (BYPASS) begin
            chk("raw_release_same", in_ready, 1);
            @(negedge clk);
            wb_valid = 1'b0; in_valid = 1'b0;
        end else begin
            chk("raw_release_same", in_ready, 0);
            @(negedge clk);
            wb_valid = 1'b0;
            #1 chk("raw_release_next", in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("raw_out_addr", out_addr, 9);
        idle();
        retire(5'd9);
        chk("raw_clean", busy, 0);

        // illegal selector leaves mask alone
        in_valid = 1'b1; sel = 3'b000; addr0 = 5'd6; wr_en = 1'b1;
        @(negedge clk);
        sel = 3'b110;
        #1 chk("ill_in_ready", in_ready, 1);
        @(negedge clk);
        idle();
        chk("ill_err", out_err, 1);
        chk("ill_addr", out_addr, 0);
        chk("ill_busy", busy, 1);
        retire(5'd6);
        chk("ill_no_set", busy, 0);

        // backpressure hold
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 3'b000; addr0 = 5'd20;
        @(negedge clk);
        addr0 = 5'd21;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_addr", out_addr, 20);
            chk("bp_hold_valid", out_valid, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_resume", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_new_addr", out_addr, 21);

        // register 0 never pends
        idle();
        in_valid = 1'b1; sel = 3'b000; addr0 = 5'd0; wr_en = 1'b1;
        @(negedge clk);
        chk("zero_busy0", busy, 0);
        src_a = 5'd0;
        #1 chk("zero_no_stall", in_ready, 1);
        @(negedge clk);
        idle();
        chk("zero_busy1", busy, 0);

        // asynchronous reset with 4 pending
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; sel = 3'b000; addr0 = AW'(i); wr_en = 1'b1;
            @(negedge clk);
        end
        addr0 = 5'd5; out_ready = 1'b0;
        @(negedge clk);
        chk("arst_busy_before", busy, 1);
        chk("arst_valid_before", out_valid, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        @(negedge clk);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // randomized run against the model
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_valid = 1'b0; m_addr = '0; m_err = 1'b0;
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom % 4) != 0;
            sel       = 3'($urandom_range(0, 7));
            addr0     = AW'($urandom_range(0, 7));
            addr1     = AW'($urandom_range(0, 7));
            addr2     = AW'($urandom_range(0, 7));
            wr_en     = 1'($urandom % 2);
            src_a     = AW'($urandom_range(0, 7));
            src_b     = AW'($urandom_range(0, 7));
            out_ready = ($urandom % 4) != 0;
            wb_valid  = ($urandom % 2) != 0;
            k = $urandom_range(0, 9);
            wb_addr   = (k == 8) ? 5'd29 : (k == 9) ? 5'd31 : AW'(k);

            d  = ref_dst(sel, addr0, addr1, addr2);
            hz = ref_is_pend(src_a) || ref_is_pend(src_b) || ref_is_pend(d);
            exp_rdy = (!m_valid || out_ready) && !hz;
            #1;
            chk("rnd_in_ready", in_ready, exp_rdy);
            chk("rnd_out_valid", out_valid, m_valid);
            chk("rnd_out_addr", out_addr, m_addr);
            chk("rnd_out_err", out_err, m_err);
            chk("rnd_busy", busy, ref_busy());

            acc = in_valid && exp_rdy;
            if (wb_valid) m_pend[wb_addr] = 1'b0;
            if (acc && wr_en && ref_legal(sel) && d != 0) m_pend[d] = 1'b1;
            if (acc) begin
                m_valid = 1'b1;
                m_addr  = d;
                m_err   = !ref_legal(sel);
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
